mix_columns: RTL and testbench
==============================

# mix_columns

Iterative AES MixColumns / InvMixColumns stage; sits directly downstream of the ShiftRows stage in the round datapath and consumes its 128-bit `Shifted_Data` / `done` outputs. Processes one 32-bit state column per clock over four cycles, trading throughput for a single shared GF(2^8) column multiplier. The `mode` input selects forward (encryption) or inverse (decryption) matrices, so one instance serves both round pipelines.

## Interface
- No parameters.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset; dominates all other inputs.
- `enable`  input  1  start request; sampled only in IDLE.
- `mode`  input  1  0 = MixColumns, 1 = InvMixColumns; captured at start.
- `Data`  input  128  state in, bit 0 = MSB; column c = `Data[32c +: 32]`, row r byte of column c = `Data[32c+8r +: 8]`.
- `Mixed_Data`  output  128  result, same byte ordering; registered.
- `done`  output  1  one-cycle pulse; `Mixed_Data` holds the new result from this cycle on.
- `busy`  output  1  high while in BUSY; `enable` ignored.

## Operation
- Registers: `state_q` (128, captured Data), `work_q` (128, partial result), `col_q` (2-bit counter), `mode_q`, FSM state.
- FSM states: IDLE, BUSY.
- IDLE, `enable`=1: `state_q`<=Data, `mode_q`<=mode, `col_q`<=0, go BUSY. `done`<=0.
- IDLE, `enable`=0: hold; `done`<=0.
- BUSY: column `col_q` of `state_q` through the column multiplier, result written to same column of `work_q`; `col_q` increments (wraps 3->0).
- BUSY with `col_q`=3: `Mixed_Data`<={work_q columns 0-2, column-3 result}, `done`<=1, go IDLE.
- `enable`, `mode`, `Data` changes during BUSY have no effect; `Data` need only be valid at the start edge.
- `Mixed_Data` changes only on the completion edge or reset; otherwise holds last result.
- GF(2^8) arithmetic, poly 0x11B: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00); all sums XOR; every intermediate 8 bits.
- Forward, column bytes s0..s3: s0'=2s0^3s1^s2^s3; s1'=s0^2s1^3s2^s3; s2'=s0^s1^2s2^3s3; s3'=3s0^s1^s2^2s3.
- Inverse: coefficient rows {0E,0B,0D,09}, {09,0E,0B,0D}, {0D,09,0E,0B}, {0B,0D,09,0E}; built from chained xtime (x4, x8) plus XOR, no lookup tables.
- Reset (any state, incl. mid-BUSY): FSM IDLE, `col_q`=0, `Mixed_Data`=0, `done`=0, `busy`=0, `state_q`/`work_q`/`mode_q`=0; in-flight operation discarded, no `done`.
- Reset and `enable` both high: reset wins, no start.

## Timing
- Start edge E (IDLE, `enable`=1). Columns 0..3 computed on edges E+1..E+4.
- Edge E+4: `Mixed_Data` updated, `done`=1 for cycle E+4..E+5; latency 4 cycles from start edge to valid output.
- `busy`=1 from edge E to edge E+4 (4 cycles).
- Earliest next start: edge E+5; `done` deasserts on that same edge. Max throughput: one block per 5 cycles.
- Upstream `done` may drive `enable` directly; upstream `Shifted_Data` is stable the cycle `done` is high, which is the only cycle sampled.
- Combinational path per cycle: one 32-bit column multiplier plus 4:1 column select (by `col_q`).

## Test plan
- Reset: assert `reset` 2 cycles, `enable`=1 throughout -> `Mixed_Data`=0, `done`=0, `busy`=0 every cycle; no start afterward until `enable` seen with `reset`=0.
- Forward FIPS-197 vector: mode=0, Data=db135345_f20a225c_01010101_2d26314c -> 4 cycles later `Mixed_Data`=8e4da1bc_9fdc589d_01010101_4d7ebdf8, `done` high exactly 1 cycle, `busy` high 4 cycles.
- Inverse: mode=1, Data=8e4da1bc_9fdc589d_01010101_4d7ebdf8 -> `Mixed_Data`=db135345_f20a225c_01010101_2d26314c; also c6c6c6c6 and d4d4d4d5 columns round-trip (forward d4d4d4d5 -> d5d5d7d6).
- Ignore while busy: start with vector A, toggle `enable`/`mode`/`Data` on cycles E+1..E+3 -> result equals A's, single `done`, no extra start.
- Back-to-back: `enable` held high continuously, alternating vectors -> `done` pulses every 5 cycles, each result correct, `Mixed_Data` stable between pulses.
- Reset mid-op: assert `reset` at edge E+2 -> no `done`, outputs 0; next start produces correct result with full 4-cycle latency.

Source files
------------

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - iterative AES MixColumns/InvMixColumns, one column per clock
module mix_columns (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           mode,
    input  logic [0:127]   Data,
    output logic [0:127]   Mixed_Data,
    output logic           done,
    output logic           busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        fsm_q, fsm_d;
    logic [0:127]  state_q, state_d;
    logic [0:127]  work_q, work_d;
    logic [0:127]  mixed_q, mixed_d;
    logic [1:0]    col_q, col_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic [31:0]   col_in;
    logic [31:0]   col_out;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Shared column multiplier; byte s0 (row 0) sits in bits [31:24].
    // Inverse coefficients are composed from x2/x4/x8 multiples:
    // 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0]  s  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] o;
        logic [1:0]  i0, i1, i2, i3;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            s[k]  = c[31-8*k -: 8];
            x2[k] = xtime(s[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
        end
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = i0 + 2'd1;
            i2 = i0 + 2'd2;
            i3 = i0 + 2'd3;
            if (!inv) begin
                o[31-8*r -: 8] = x2[i0] ^ (x2[i1] ^ s[i1]) ^ s[i2] ^ s[i3];
            end else begin
                o[31-8*r -: 8] = (x8[i0] ^ x4[i0] ^ x2[i0]) ^
                                 (x8[i1] ^ x2[i1] ^ s[i1])  ^
                                 (x8[i2] ^ x4[i2] ^ s[i2])  ^
                                 (x8[i3] ^ s[i3]);
            end
        end
        return o;
    endfunction

    // Select the active column of the captured state and mix it.
    always_comb begin
        col_in = state_q[0:31];
        case (col_q)
            2'd0: col_in = state_q[0:31];
            2'd1: col_in = state_q[32:63];
            2'd2: col_in = state_q[64:95];
            2'd3: col_in = state_q[96:127];
            default: col_in = state_q[0:31];
        endcase
        col_out = mix_col(col_in, mode_q);
    end

    // Next-state logic: capture on start, one column per BUSY cycle, publish on column 3.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        work_d  = work_q;
        mixed_d = mixed_q;
        col_d   = col_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (enable) begin
                    state_d = Data;
                    mode_d  = mode;
                    col_d   = 2'd0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                case (col_q)
                    2'd0: work_d[0:31]   = col_out;
                    2'd1: work_d[32:63]  = col_out;
                    2'd2: work_d[64:95]  = col_out;
                    2'd3: work_d[96:127] = col_out;
                    default: work_d = work_q;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    mixed_d = {work_q[0:95], col_out};
                    done_d  = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that discards any in-flight block.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            work_q  <= '0;
            mixed_q <= '0;
            col_q   <= 2'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            work_q  <= work_d;
            mixed_q <= mixed_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign Mixed_Data = mixed_q;
    assign done       = done_q;
    assign busy       = (fsm_q == BUSY);

endmodule

// File: tb/tb_mix_columns.sv
// tb/tb_mix_columns.sv - self-checking bench for mix_columns against a GF(2^8) matrix model
module tb_mix_columns;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          mode;
    logic [0:127]  data;
    logic [0:127]  mixed;
    logic          done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    mix_columns dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .Data       (data),
        .Mixed_Data (mixed),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Full-state reference: circulant matrix applied to each column.
    function automatic logic [0:127] ref_mix(input logic [0:127] d, input logic inv);
        logic [7:0]   fwd [4];
        logic [7:0]   invc [4];
        logic [7:0]   acc;
        logic [7:0]   cf;
        logic [0:127] o;
        fwd[0] = 8'h02; fwd[1] = 8'h03; fwd[2] = 8'h01; fwd[3] = 8'h01;
        invc[0] = 8'h0E; invc[1] = 8'h0B; invc[2] = 8'h0D; invc[3] = 8'h09;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    cf  = inv ? invc[(k - r + 4) % 4] : fwd[(k - r + 4) % 4];
                    acc = acc ^ gf_mul(cf, d[32*c + 8*k +: 8]);
                end
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] rnd128();
        logic [0:127] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Launch one block and observe 8 cycles after the start edge (stimulus only).
    task automatic run_op(input logic [0:127] d, input logic m, input bit toggle,
                          output logic [0:127] got, output int lat,
                          output int busy_cnt, output int done_cnt);
        @(negedge clk);
        data   = d;
        mode   = m;
        enable = 1'b1;
        @(posedge clk);
        #1;
        lat      = -1;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        got      = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            data = rnd128();
            mode = ~mode;
            if (toggle && k <= 3) enable = 1'($urandom_range(0, 1));
            else                  enable = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    got = mixed;
                end
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        data   = rnd128();
        mode   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (mixed !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d mixed=%h done=%b busy=%b expected 0/0/0", i, mixed, done, busy);
            end
        end
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_start cycle=%0d busy=%b done=%b expected 0/0", i, busy, done);
            end
        end
    endtask

    task automatic test_fips();
        logic [0:127] vin;
        logic [0:127] vout;
        logic [0:127] got;
        int lat, bc, dc;
        vin  = 128'hdb135345_f20a225c_01010101_2d26314c;
        vout = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        run_op(vin, 1'b0, 1'b0, got, lat, bc, dc);
        total++;
        if (got !== vout || got !== ref_mix(vin, 1'b0)) begin
            bad++;
            $display("FAIL fips_forward got=%h expected=%h", got, vout);
        end
        total++;
        if (lat !== 4 || dc !== 1 || bc !== 4) begin
            bad++;
            $display("FAIL fips_forward_timing lat=%0d done_cycles=%0d busy_cycles=%0d expected 4/1/4", lat, dc, bc);
        end
        total++;
        if (mixed !== vout) begin
            bad++;
            $display("FAIL fips_forward_hold got=%h expected=%h", mixed, vout);
        end
        run_op(vout, 1'b1, 1'b0, got, lat, bc, dc);
        total++;
        if (got !== vin || lat !== 4 || dc !== 1) begin
            bad++;
            $display("FAIL fips_inverse got=%h lat=%0d done=%0d expected=%h lat=4 done=1", got, lat, dc, vin);
        end
    endtask

    task automatic test_roundtrip();
        logic [0:127] vin;
        logic [0:127] vout;
        logic [0:127] got;
        logic [0:127] back;
        int lat, bc, dc;
        vin  = 128'hc6c6c6c6_d4d4d4d5_f20a225c_01010101;
        vout = 128'hc6c6c6c6_d5d5d7d6_9fdc589d_01010101;
        run_op(vin, 1'b0, 1'b0, got, lat, bc, dc);
        total++;
        if (got !== vout) begin
            bad++;
            $display("FAIL roundtrip_fwd got=%h expected=%h", got, vout);
        end
        run_op(vout, 1'b1, 1'b0, back, lat, bc, dc);
        total++;
        if (back !== vin) begin
            bad++;
            $display("FAIL roundtrip_inv got=%h expected=%h", back, vin);
        end
        for (int i = 0; i < 6; i++) begin
            logic m;
            vin = rnd128();
            m   = 1'($urandom_range(0, 1));
            run_op(vin, m, 1'b0, got, lat, bc, dc);
            total++;
            if (got !== ref_mix(vin, m) || lat !== 4 || dc !== 1) begin
                bad++;
                $display("FAIL random_op%0d mode=%b got=%h expected=%h lat=%0d", i, m, got, ref_mix(vin, m), lat);
            end
            run_op(got, ~m, 1'b0, back, lat, bc, dc);
            total++;
            if (back !== vin) begin
                bad++;
                $display("FAIL random_roundtrip%0d got=%h expected=%h", i, back, vin);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [0:127] vin;
        logic [0:127] got;
        int lat, bc, dc;
        for (int i = 0; i < 3; i++) begin
            vin = rnd128();
            run_op(vin, 1'b0, 1'b1, got, lat, bc, dc);
            total++;
            if (got !== ref_mix(vin, 1'b0) || dc !== 1 || bc !== 4 || lat !== 4) begin
                bad++;
                $display("FAIL ignore_busy%0d got=%h expected=%h done=%0d busy=%0d lat=%0d", i, got, ref_mix(vin, 1'b0), dc, bc, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] vecs [4];
        logic         modes [4];
        logic [0:127] last;
        int           idx;
        int           cyc;
        last = mixed;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_before done=%b busy=%b expected 0/0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            vecs[i]  = rnd128();
            modes[i] = 1'(i % 2);
        end
        idx = 0;
        @(negedge clk);
        data   = vecs[0];
        mode   = modes[0];
        enable = 1'b1;
        for (cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                total++;
                if (mixed !== ref_mix(vecs[idx], modes[idx]) || cyc !== 4 + 5 * idx) begin
                    bad++;
                    $display("FAIL b2b_result%0d cycle=%0d got=%h expected=%h at cycle %0d", idx, cyc, mixed, ref_mix(vecs[idx], modes[idx]), 4 + 5 * idx);
                end
                last = ref_mix(vecs[idx], modes[idx]);
                idx++;
                @(negedge clk);
                if (idx < 4) begin
                    data = vecs[idx];
                    mode = modes[idx];
                end else begin
                    enable = 1'b0;
                end
            end else begin
                total++;
                if (mixed !== last) begin
                    bad++;
                    $display("FAIL b2b_stable cycle=%0d got=%h expected=%h", cyc, mixed, last);
                end
            end
        end
        enable = 1'b0;
        total++;
        if (idx !== 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d expected=4", idx);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:127] vin;
        logic [0:127] got;
        int lat, bc, dc;
        int stray;
        vin = rnd128();
        @(negedge clk);
        data   = vin;
        mode   = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (mixed !== 128'h0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs mixed=%h done=%b busy=%b expected 0/0/0", mixed, done, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL reset_mid_no_done got=%0d active cycles expected=0", stray);
        end
        run_op(vin, 1'b1, 1'b0, got, lat, bc, dc);
        total++;
        if (got !== ref_mix(vin, 1'b1) || lat !== 4 || dc !== 1) begin
            bad++;
            $display("FAIL reset_mid_restart got=%h expected=%h lat=%0d", got, ref_mix(vin, 1'b1), lat);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 1'b0;
        data   = '0;
        test_reset();
        test_fips();
        test_roundtrip();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
